nlfsr_seq_ctrl: RTL
===================

# nlfsr_seq_ctrl

Sequencer on the driving side of the TRNG NLFSR stage. It loads a seed serially into the NLFSR through its `d1`/`load` pins and runs the `init` mixing phase for a fixed number of cycles. It then samples the NLFSR output bit `a0` every cycle, packs the bits into words and delivers them over a valid/ready port backed by a 2-entry buffer. The NLFSR itself never stalls, so the buffer absorbs short backpressure and any remaining overflow is flagged.

## Interface
Parameters:
- `SEED_W`, 17: NLFSR length, i.e. the number of serial load cycles.
- `INIT_CYCLES`, 64: number of mixing cycles with `init`=1; must be ≥1.
- `WORD_W`, 16: output word width; must be ≥2.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: single-cycle request; `seed` is sampled in the same cycle.
- `seed` in SEED_W: seed value, shifted out LSB first.
- `stop` in 1: ends RUN.
- `load` out 1: drives the NLFSR `load` pin.
- `init` out 1: drives the NLFSR `init` pin.
- `d1` out 1: serial seed bit.
- `a0` in 1: NLFSR output bit.
- `busy` out 1: high in any state other than IDLE.
- `out_data` out WORD_W: head word of the buffer.
- `out_valid` out 1: buffer not empty.
- `out_ready` in 1: consumer accepts the head word.
- `ovr` out 1: sticky overrun flag, cleared by `start`.

## Operation
- States are IDLE, LOAD, INIT and RUN. All outputs are registered.
- IDLE:
  - `start`=1 captures `seed` into the shift register, flushes the buffer, clears `ovr` and enters LOAD.
  - `stop` has no effect in IDLE.
- LOAD (SEED_W cycles):
  - `load`=1 and `d1`=seed[k] in the k-th LOAD cycle, k=0..SEED_W-1.
  - After the final cycle the NLFSR holds seed[0] in bit 0.
  - The block then enters INIT.
- INIT (INIT_CYCLES cycles): `init`=1, `load`=0, `d1`=0, then the block enters RUN.
- RUN:
  - `load`=`init`=0.
  - `a0` is sampled every cycle into bit position `bitcnt` of the packing register, filled LSB first.
  - When `bitcnt` reaches WORD_W-1 the completed word is pushed into the buffer and `bitcnt` wraps to 0.
- Buffer (2-entry FIFO):
  - A pop occurs when `out_valid`·`out_ready`.
  - A push and a pop in the same cycle are always accepted, including when the buffer is full.
  - If a push arrives while the buffer is full and there is no pop, the word is dropped, `ovr` is set and the buffer contents are unchanged.
- `stop` in RUN returns the block to IDLE on the next edge:
  - the partial word is discarded and `bitcnt` is cleared;
  - buffered words remain available.
- If `stop` and a word completion fall in the same RUN cycle, the completed word is still pushed.
- `start` while `busy`=1 is ignored.
- Reset, including mid-operation: state=IDLE, `load`=`init`=`d1`=`busy`=0, `out_valid`=0, `out_data`=0, `ovr`=0, counters=0, buffer empty.

## Timing
- The `start` edge is cycle 0.
- LOAD occupies cycles 1..SEED_W.
- INIT occupies cycles SEED_W+1..SEED_W+INIT_CYCLES.
- The first RUN sample is taken at cycle SEED_W+INIT_CYCLES+1.
- The first word's `out_valid` rises one cycle after its WORD_W-th sample, i.e. at the earliest at cycle SEED_W+INIT_CYCLES+WORD_W+1.
- Steady state produces one word every WORD_W cycles. With WORD_W≥2, a consumer that pops at least once per WORD_W cycles never causes an overrun.
- `busy` rises at cycle 1 and falls on the cycle after `stop` is sampled in RUN.

## Configuration
- Macro `NLFSR_SEQ_OVR_CNT_EN`.
- When defined:
  - the block adds output port `ovr_cnt` (8 bits);
  - `ovr_cnt` counts dropped words and saturates at 255;
  - it is cleared by reset and by an accepted `start`.
- When undefined, the port and counter are absent and only the sticky `ovr` flag exists.

## Structure
- Shared package `trng_pkg` holds:
  - the state enum `seq_state_t` (IDLE, LOAD, INIT, RUN);
  - the default constants for SEED_W, INIT_CYCLES and WORD_W.
- Sub-module `trng_word_fifo2`: the parameterised 2-entry FIFO, with width WORD_W, a push port, a pop port and a `drop` pulse output.
- The FSM, counters and packer stay in `nlfsr_seq_ctrl`.

## Test plan
- Seed load:
  - stimulus: `start` with `seed`=17'h1A5C3, defaults;
  - required: `load`=1 for exactly 17 cycles (1..17);
  - required: the `d1` sequence equals seed bits 0..16 in order, and `init` is 1 for cycles 18..81.
- Packing:
  - stimulus: drive `a0` with the pattern 1,0,0,0,... repeated, `out_ready`=1;
  - required: every word is 16'h1111, `out_valid` first rises at cycle 98, and a word arrives every 16 cycles after that.
- Overrun:
  - stimulus: hold `out_ready`=0 through RUN;
  - required: `out_valid` stays 1 after the first word, the buffer holds words 1 and 2, and `ovr` rises when word 3 completes;
  - required: with `NLFSR_SEQ_OVR_CNT_EN` defined, `ovr_cnt`=3 after 5 words.
- Stop and restart:
  - stimulus: `stop` mid-word in RUN;
  - required: `busy`=0 next cycle and buffered words are still poppable;
  - stimulus: a new `start`;
  - required: the buffer is flushed and `ovr` is cleared.
- Ignored `start`: a `start` during INIT changes neither the seed nor the timing.
- Reset mid-LOAD:
  - stimulus: `rst_n`=0 at cycle 5;
  - required: all outputs go to 0 asynchronously and the block stays IDLE until the next `start`.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared TRNG definitions: sequencer state encoding and default sizing.
package trng_pkg;

    localparam int unsigned DEF_SEED_W      = 17;
    localparam int unsigned DEF_INIT_CYCLES = 64;
    localparam int unsigned DEF_WORD_W      = 16;
    localparam int unsigned OVR_CNT_W       = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        INIT = 2'd2,
        RUN  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/nlfsr_seq_ctrl_if.sv
// Valid/ready word port of the NLFSR sequencer.
//   out_data  : head word of the output buffer
//   out_valid : buffer not empty
//   out_ready : consumer accepts the head word
// master = producer (sequencer), slave = consumer.
interface nlfsr_seq_ctrl_if
    import trng_pkg::*;
#(
    parameter int unsigned WORD_W = DEF_WORD_W
) ();

    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/trng_word_fifo2.sv
// Two-entry word FIFO with flush. A push while full is dropped (drop pulse)
// unless a pop happens in the same cycle.
// Ports: clk, rst_n, flush, push/push_data, pop_ready,
//        head_data/head_valid (registered), drop (same-cycle pulse).
module trng_word_fifo2
    import trng_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic             drop
);

    logic [WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             pop_c;

    // Entry 0 is always the head; entries shift down on pop.
    always_comb begin
        e0_d   = e0_q;
        e1_d   = e1_q;
        cnt_d  = cnt_q;
        drop   = 1'b0;
        pop_c  = valid_q & pop_ready;
        if (flush) begin
            e0_d  = '0;
            e1_d  = '0;
            cnt_d = 2'd0;
        end else begin
            case ({push, pop_c})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        e0_d  = push_data;
                        cnt_d = 2'd1;
                    end else if (cnt_q == 2'd1) begin
                        e1_d  = push_data;
                        cnt_d = 2'd2;
                    end else begin
                        drop = 1'b1;
                    end
                end
                2'b01: begin
                    e0_d  = e1_q;
                    e1_d  = '0;
                    cnt_d = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        e0_d = push_data;
                    end else begin
                        e0_d = e1_q;
                        e1_d = push_data;
                    end
                end
                default: ;
            endcase
        end
        valid_d = (cnt_d != 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q    <= '0;
            e1_q    <= '0;
            cnt_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign head_data  = e0_q;
    assign head_valid = valid_q;

endmodule

// File: rtl/nlfsr_seq_ctrl.sv
// NLFSR driving-side sequencer: serial seed load, init mixing, then packs
// the a0 stream LSB-first into words delivered through a 2-entry buffer.
// Ports: clk, rst_n, start/seed, stop, load/init/d1 (NLFSR pins), a0,
//        busy, ovr (sticky overrun), out_if (valid/ready word port),
//        ovr_cnt (saturating drop count, only with NLFSR_SEQ_OVR_CNT_EN).
module nlfsr_seq_ctrl
    import trng_pkg::*;
#(
    parameter int unsigned SEED_W      = DEF_SEED_W,
    parameter int unsigned INIT_CYCLES = DEF_INIT_CYCLES,
    parameter int unsigned WORD_W      = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [SEED_W-1:0] seed,
    input  logic              stop,
    output logic              load,
    output logic              init,
    output logic              d1,
    input  logic              a0,
    output logic              busy,
    output logic              ovr,
`ifdef NLFSR_SEQ_OVR_CNT_EN
    output logic [OVR_CNT_W-1:0] ovr_cnt,
`endif
    nlfsr_seq_ctrl_if.master  out_if
);

    localparam int unsigned CNT_MAX = (SEED_W > INIT_CYCLES) ? SEED_W : INIT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned BIT_W   = $clog2(WORD_W);

    seq_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEED_W-1:0] sr_q, sr_d;
    logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;
    logic [WORD_W-1:0] pack_q, pack_d;
    logic              load_q, load_d, init_q, init_d, d1_q, d1_d;
    logic              busy_q, busy_d, ovr_q, ovr_d;
    logic              push_c, flush_c, drop_c;
    logic [WORD_W-1:0] word_c;
    logic [WORD_W-1:0] head_data;
    logic              head_valid;

    // Next-state, pin drive and packer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        bitcnt_d = bitcnt_q;
        pack_d   = pack_q;
        load_d   = 1'b0;
        init_d   = 1'b0;
        d1_d     = 1'b0;
        push_c   = 1'b0;
        flush_c  = 1'b0;
        word_c   = pack_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    // seed[0] goes out with this edge; the rest is queued.
                    sr_d    = seed >> 1;
                    load_d  = 1'b1;
                    d1_d    = seed[0];
                    flush_c = 1'b1;
                end
            end
            LOAD: begin
                if (cnt_q == CNT_W'(SEED_W - 1)) begin
                    state_d = INIT;
                    cnt_d   = '0;
                    init_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    load_d = 1'b1;
                    d1_d   = sr_q[0];
                    sr_d   = sr_q >> 1;
                end
            end
            INIT: begin
                if (cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    init_d = 1'b1;
                end
            end
            RUN: begin
                pack_d[bitcnt_q] = a0;
                if (bitcnt_q == BIT_W'(WORD_W - 1)) begin
                    push_c   = 1'b1;
                    word_c   = pack_d;
                    pack_d   = '0;
                    bitcnt_d = '0;
                end else begin
                    bitcnt_d = bitcnt_q + BIT_W'(1);
                end
                // A word completing on the stop cycle has already been pushed.
                if (stop) begin
                    state_d  = IDLE;
                    bitcnt_d = '0;
                    pack_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Sticky overrun flag; kept apart from the FSM block since drop depends on push.
    always_comb begin
        ovr_d = ovr_q;
        if (flush_c) begin
            ovr_d = 1'b0;
        end else if (drop_c) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sr_q     <= '0;
            bitcnt_q <= '0;
            pack_q   <= '0;
            load_q   <= 1'b0;
            init_q   <= 1'b0;
            d1_q     <= 1'b0;
            busy_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
            bitcnt_q <= bitcnt_d;
            pack_q   <= pack_d;
            load_q   <= load_d;
            init_q   <= init_d;
            d1_q     <= d1_d;
            busy_q   <= busy_d;
            ovr_q    <= ovr_d;
        end
    end

`ifdef NLFSR_SEQ_OVR_CNT_EN
    logic [OVR_CNT_W-1:0] ovr_cnt_q, ovr_cnt_d;

    // Saturating count of dropped words.
    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        if (flush_c) begin
            ovr_cnt_d = '0;
        end else if (drop_c && (ovr_cnt_q != '1)) begin
            ovr_cnt_d = ovr_cnt_q + OVR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_cnt_q <= '0;
        end else begin
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign ovr_cnt = ovr_cnt_q;
`endif

    trng_word_fifo2 #(.WIDTH(WORD_W)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush_c),
        .push       (push_c),
        .push_data  (word_c),
        .pop_ready  (out_if.out_ready),
        .head_data  (head_data),
        .head_valid (head_valid),
        .drop       (drop_c)
    );

    assign out_if.out_data  = head_data;
    assign out_if.out_valid = head_valid;
    assign load = load_q;
    assign init = init_q;
    assign d1   = d1_q;
    assign busy = busy_q;
    assign ovr  = ovr_q;

endmodule
